subsurf_sequencer: RTL and testbench

Top-level phase controller for the subdivision-surface engine. Accepts a job start with vertex and face counts, kicks the `neighbor` pass, then the `averager` pass, and reports completion. Owns the three shared RAM ports (OBJ, NBR, RES) and multiplexes them to whichever engine is active. Optionally runs a hang watchdog on each pass.

---
 rtl/subsurf_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_subsurf_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/subsurf_sequencer.sv
// Phase controller for the subdivision-surface engine: runs neighbor then averager and
// multiplexes the shared OBJ/NBR/RES RAM ports. Optional hang watchdog: SUBSURF_WATCHDOG_EN.
module subsurf_sequencer #(
    parameter int unsigned START_PULSE = 2,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] vertex_count_in,
    input  logic [31:0] face_count_in,
    output logic [31:0] vertex_count,
    output logic [31:0] face_count,
    output logic        nbr_start,
    input  logic        nbr_busy,
    output logic        avg_start,
    input  logic        avg_busy,
    input  logic        en0_n,
    input  logic        en1_n,
    input  logic [8:0]  a0_n,
    input  logic [8:0]  a1_n,
    input  logic [3:0]  we0_n,
    input  logic [3:0]  we1_n,
    input  logic [31:0] di0_n,
    input  logic [31:0] di1_n,
    input  logic        en0_a,
    input  logic        en1_a,
    input  logic        en2_a,
    input  logic [8:0]  a0_a,
    input  logic [8:0]  a1_a,
    input  logic [8:0]  a2_a,
    input  logic [3:0]  we0_a,
    input  logic [3:0]  we1_a,
    input  logic [3:0]  we2_a,
    input  logic [31:0] di0_a,
    input  logic [31:0] di1_a,
    input  logic [31:0] di2_a,
    output logic        en0,
    output logic        en1,
    output logic        en2,
    output logic [8:0]  a0,
    output logic [8:0]  a1,
    output logic [8:0]  a2,
    output logic [3:0]  we0,
    output logic [3:0]  we1,
    output logic [3:0]  we2,
    output logic [31:0] di0,
    output logic [31:0] di1,
    output logic [31:0] di2,
    output logic        busy,
    output logic        done,
    output logic [1:0]  phase,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StNbrKick,
        StNbrWait,
        StAvgKick,
        StAvgWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pulse_q, pulse_d;
    logic [31:0] vcount_q, vcount_d;
    logic [31:0] fcount_q, fcount_d;
    // A zero-count job lingers one extra cycle in DONE so its done pulse lands in cycle 2.
    logic        skip_q, skip_d;
    logic        pulse_last;
    logic        wait_busy;
    logic        wdog_hit;

    assign pulse_last = (pulse_q == START_PULSE - 1);
    assign wait_busy  = ((state_q == StNbrWait) && nbr_busy) ||
                        ((state_q == StAvgWait) && avg_busy);

`ifdef SUBSURF_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        err_q, err_d;

    // Firing on the cycle the count would reach the limit bounds each wait to WDOG_CYCLES cycles.
    assign wdog_hit = (wdog_q == WDOG_CYCLES - 1);

    always_comb begin
        wdog_d = '0;
        err_d  = err_q;
        if (wait_busy) begin
            wdog_d = wdog_q + 32'd1;
        end
        if ((state_q == StIdle) && start) begin
            err_d = 1'b0;
        end else if (wait_busy && wdog_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign error = err_q;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_hit    = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pulse_d  = '0;
        skip_d   = skip_q;
        vcount_d = vcount_q;
        fcount_d = fcount_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    vcount_d = vertex_count_in;
                    fcount_d = face_count_in;
                    skip_d   = (vertex_count_in == '0) || (face_count_in == '0);
                    state_d  = skip_d ? StDone : StNbrKick;
                end
            end
            StNbrKick: begin
                if (pulse_last) begin
                    state_d = StNbrWait;
                end else begin
                    pulse_d = pulse_q + 32'd1;
                end
            end
            StNbrWait: begin
                if (!nbr_busy) begin
                    state_d = StAvgKick;
                end else if (wdog_hit) begin
                    state_d = StDone;
                end
            end
            StAvgKick: begin
                if (pulse_last) begin
                    state_d = StAvgWait;
                end else begin
                    pulse_d = pulse_q + 32'd1;
                end
            end
            StAvgWait: begin
                if (!avg_busy || wdog_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (skip_q) begin
                    skip_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pulse_q  <= '0;
            skip_q   <= 1'b0;
            vcount_q <= '0;
            fcount_q <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            skip_q   <= skip_d;
            vcount_q <= vcount_d;
            fcount_q <= fcount_d;
        end
    end

    assign vertex_count = vcount_q;
    assign face_count   = fcount_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone) && !skip_q;
    assign nbr_start    = (state_q == StNbrKick);
    assign avg_start    = (state_q == StAvgKick);

    always_comb begin
        phase = 2'd0;
        case (state_q)
            StNbrKick, StNbrWait: phase = 2'd1;
            StAvgKick, StAvgWait: phase = 2'd2;
            StDone:               phase = 2'd3;
            default:              phase = 2'd0;
        endcase
    end

    always_comb begin
        en0 = 1'b0;
        en1 = 1'b0;
        en2 = 1'b0;
        a0  = '0;
        a1  = '0;
        a2  = '0;
        we0 = '0;
        we1 = '0;
        we2 = '0;
        di0 = '0;
        di1 = '0;
        di2 = '0;
        case (state_q)
            StNbrKick, StNbrWait: begin
                en0 = en0_n;
                en1 = en1_n;
                a0  = a0_n;
                a1  = a1_n;
                we0 = we0_n;
                we1 = we1_n;
                di0 = di0_n;
                di1 = di1_n;
            end
            StAvgKick, StAvgWait: begin
                en0 = en0_a;
                en1 = en1_a;
                en2 = en2_a;
                a0  = a0_a;
                a1  = a1_a;
                a2  = a2_a;
                we0 = we0_a;
                we1 = we1_a;
                we2 = we2_a;
                di0 = di0_a;
                di1 = di1_a;
                di2 = di2_a;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_subsurf_sequencer.sv
// Randomized self-checking bench for subsurf_sequencer against a job-schedule reference model.
module tb_subsurf_sequencer;

    localparam int P = 2;
    localparam int W = 8;
`ifdef SUBSURF_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk, rst_n, start;
    logic [31:0] vertex_count_in, face_count_in, vertex_count, face_count;
    logic        nbr_start, nbr_busy, avg_start, avg_busy;
    logic        en0_n, en1_n, en0_a, en1_a, en2_a, en0, en1, en2;
    logic [8:0]  a0_n, a1_n, a0_a, a1_a, a2_a, a0, a1, a2;
    logic [3:0]  we0_n, we1_n, we0_a, we1_a, we2_a, we0, we1, we2;
    logic [31:0] di0_n, di1_n, di0_a, di1_a, di2_a, di0, di1, di2;
    logic        busy, done, error;
    logic [1:0]  phase;

    subsurf_sequencer #(.START_PULSE(P), .WDOG_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vertex_count_in(vertex_count_in), .face_count_in(face_count_in),
        .vertex_count(vertex_count), .face_count(face_count),
        .nbr_start(nbr_start), .nbr_busy(nbr_busy), .avg_start(avg_start), .avg_busy(avg_busy),
        .en0_n(en0_n), .en1_n(en1_n), .a0_n(a0_n), .a1_n(a1_n),
        .we0_n(we0_n), .we1_n(we1_n), .di0_n(di0_n), .di1_n(di1_n),
        .en0_a(en0_a), .en1_a(en1_a), .en2_a(en2_a), .a0_a(a0_a), .a1_a(a1_a), .a2_a(a2_a),
        .we0_a(we0_a), .we1_a(we1_a), .we2_a(we2_a), .di0_a(di0_a), .di1_a(di1_a), .di2_a(di2_a),
        .en0(en0), .en1(en1), .en2(en2), .a0(a0), .a1(a1), .a2(a2),
        .we0(we0), .we1(we1), .we2(we2), .di0(di0), .di1(di1), .di2(di2),
        .busy(busy), .done(done), .phase(phase), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Engine model: busy for eng_l cycles starting the cycle its start is first seen.
    int   eng_l, eng_la, nbr_rem, avg_rem;
    logic nbr_prev, avg_prev;
    logic [31:0] exp_vc, exp_fc;
    logic        exp_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cycle();
        en0_n = 1'($urandom); en1_n = 1'($urandom);
        en0_a = 1'($urandom); en1_a = 1'($urandom); en2_a = 1'($urandom);
        a0_n = 9'($urandom); a1_n = 9'($urandom);
        a0_a = 9'($urandom); a1_a = 9'($urandom); a2_a = 9'($urandom);
        we0_n = 4'($urandom); we1_n = 4'($urandom);
        we0_a = 4'($urandom); we1_a = 4'($urandom); we2_a = 4'($urandom);
        di0_n = $urandom; di1_n = $urandom;
        di0_a = $urandom; di1_a = $urandom; di2_a = $urandom;
        if (nbr_start && !nbr_prev) nbr_rem = eng_l;
        if (avg_start && !avg_prev) avg_rem = eng_la;
        nbr_prev = nbr_start;
        avg_prev = avg_start;
        nbr_busy = (nbr_rem > 0);
        avg_busy = (avg_rem > 0);
        if (nbr_rem > 0) nbr_rem--;
        if (avg_rem > 0) avg_rem--;
    endtask

    task automatic check_cycle(input string tag, input int ep, input bit ens, input bit eas,
                               input bit ed, input bit eb);
        logic [45:0] p0, p1, p2;
        p0 = '0; p1 = '0; p2 = '0;
        if (ep == 1) begin
            p0 = {en0_n, a0_n, we0_n, di0_n};
            p1 = {en1_n, a1_n, we1_n, di1_n};
        end else if (ep == 2) begin
            p0 = {en0_a, a0_a, we0_a, di0_a};
            p1 = {en1_a, a1_a, we1_a, di1_a};
            p2 = {en2_a, a2_a, we2_a, di2_a};
        end
        chk({tag, " phase"}, 64'(phase), 64'(ep));
        chk({tag, " busy"}, 64'(busy), 64'(eb));
        chk({tag, " done"}, 64'(done), 64'(ed));
        chk({tag, " nbr_start"}, 64'(nbr_start), 64'(ens));
        chk({tag, " avg_start"}, 64'(avg_start), 64'(eas));
        chk({tag, " vertex_count"}, 64'(vertex_count), 64'(exp_vc));
        chk({tag, " face_count"}, 64'(face_count), 64'(exp_fc));
        chk({tag, " error"}, 64'(error), 64'(exp_err));
        chk({tag, " port0"}, 64'({en0, a0, we0, di0}), 64'(p0));
        chk({tag, " port1"}, 64'({en1, a1, we1, di1}), 64'(p1));
        chk({tag, " port2"}, 64'({en2, a2, we2, di2}), 64'(p2));
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        nbr_rem = 0; avg_rem = 0; nbr_prev = 1'b0; avg_prev = 1'b0;
        nbr_busy = 1'b0; avg_busy = 1'b0; start = 1'b0;
        exp_vc = '0; exp_fc = '0; exp_err = 1'b0;
        check_cycle({tag, " async"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_cycle();
        #1;
        check_cycle({tag, " held"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // One job from the start cycle (k=0) until the cycle after done, or until abort_at.
    task automatic run_job(input string tag, input logic [31:0] vc, input logic [31:0] fc,
                           input int l, input int la, input bit glitch, input int abort_at);
        bit zero, nbr_to, tmo;
        int c_end, done_cyc, ep;
        bit ens, eas, ed, eb;
        zero = (vc == 0) || (fc == 0);
        nbr_to = 1'b0; tmo = 1'b0; c_end = 0;
        eng_l = l; eng_la = la;
        if (zero) begin
            done_cyc = 2;
        end else if (WD && (l + 1 > P + W)) begin
            nbr_to = 1'b1; tmo = 1'b1;
            done_cyc = P + W + 1;
            c_end = done_cyc - 1;
        end else begin
            c_end = (l + 1 > P + 1) ? l + 1 : P + 1;
            if (WD && (la + 1 > P + W)) begin
                tmo = 1'b1;
                done_cyc = c_end + P + W + 1;
            end else begin
                done_cyc = ((la + 1 > P + 1) ? c_end + la + 1 : c_end + P + 1) + 1;
            end
        end

        @(posedge clk); #1;
        start = 1'b1; vertex_count_in = vc; face_count_in = fc;
        drive_cycle();
        #1;
        check_cycle({tag, " k0"}, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_vc = vc; exp_fc = fc; exp_err = 1'b0;

        for (int k = 1; k <= done_cyc + 1; k++) begin
            @(posedge clk); #1;
            ep = 0; ens = 1'b0; eas = 1'b0; ed = 1'b0; eb = 1'b0;
            if (k <= done_cyc) begin
                eb = 1'b1;
                if (zero || k == done_cyc) ep = 3;
                else if (k <= c_end) ep = 1;
                else ep = 2;
                ens = !zero && (k <= P);
                eas = !zero && !nbr_to && (k > c_end) && (k <= c_end + P);
                ed = (k == done_cyc);
            end
            if (k >= done_cyc) exp_err = tmo;
            start = 1'b0;
            if (glitch && (ep == 2 || ep == 3)) begin
                start = 1'b1;
                vertex_count_in = $urandom;
                face_count_in = $urandom;
            end
            drive_cycle();
            #1;
            check_cycle($sformatf("%s k%0d", tag, k), ep, ens, eas, ed, eb);
            if (k == abort_at) begin
                do_reset({tag, " reset"});
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; vertex_count_in = '0; face_count_in = '0;
        nbr_busy = 1'b0; avg_busy = 1'b0;
        nbr_rem = 0; avg_rem = 0; nbr_prev = 1'b0; avg_prev = 1'b0; eng_l = 0; eng_la = 0;
        exp_vc = '0; exp_fc = '0; exp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive_cycle();
        #1;
        check_cycle("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        run_job("basic", 32'd12, 32'd20, 10, 10, 1'b0, 0);
        run_job("zero_vtx", 32'd0, 32'd7, 4, 4, 1'b0, 0);
        run_job("ignore_start", 32'd5, 32'd9, 3, 6, 1'b1, 0);
        run_job("abort", 32'd33, 32'd44, 10, 3, 1'b0, 5);
        run_job("after_abort", 32'd6, 32'd2, 4, 5, 1'b0, 0);
        run_job("min_latency", 32'd7, 32'd8, 0, 0, 1'b0, 0);
        run_job("zero_face", 32'd3, 32'd0, 2, 2, 1'b1, 0);
        for (int j = 0; j < 10; j++) begin
            logic [31:0] rv, rf;
            rv = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            rf = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            run_job($sformatf("rand%0d", j), rv, rf, int'($urandom_range(0, 6)),
                    int'($urandom_range(0, 6)), 1'($urandom), 0);
        end
`ifdef SUBSURF_WATCHDOG_EN
        run_job("wdog_nbr", 32'd3, 32'd4, 100, 0, 1'b0, 0);
        run_job("wdog_clear", 32'd1, 32'd1, 1, 1, 1'b0, 0);
        run_job("wdog_avg", 32'd9, 32'd9, 1, 100, 1'b0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
